// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the SRAM access scheduler.
package mem_sched_pkg;

  localparam int MEM_AW = 10;
  localparam int MEM_DW = 16;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after rr_ptr.
// Latency: grant is combinational from req/en/rr_ptr; pointer updates on the next edge.
// Backpressure: en=0 suppresses all grants; ungranted requesters simply hold req.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gnt_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Walk requesters starting at the pointer, wrapping modulo NREQ.
      if (int'(rr_ptr) + k >= NREQ) begin
        cand = IW'(int'(rr_ptr) + k - NREQ);
      end else begin
        cand = IW'(int'(rr_ptr) + k);
      end
      if (en && !found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (|gnt) begin
      rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mem_access_sched.sv
// Shares one single-port SRAM among NREQ requesters, gated by a settled PLL lock.
// Latency: grant -> SRAM pins next cycle; read data returned 1+RD_LATENCY cycles after grant.
// Backpressure: requesters hold req until gnt; no grants while lock is unsettled.
module mem_access_sched
  import mem_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = MEM_AW,
  parameter int DW          = MEM_DW,
  parameter int LOCK_CYCLES = 64,
  parameter int RD_LATENCY  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               ready,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_chip_en,
  output logic               mem_wr_en,
  output logic               mem_rd_en,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wr_data,
  input  logic [DW-1:0]      mem_rd_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  lock_state_e   state;
  logic [CW-1:0] lock_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!pll_lock) begin
            lock_cnt <= '0;
          end else if (lock_cnt == CW'(LOCK_CYCLES - 1)) begin
            state    <= RUN;
            ready    <= 1'b1;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        RUN: begin
          if (!pll_lock) begin
            state    <= WAIT_LOCK;
            ready    <= 1'b0;
            lock_cnt <= '0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          ready <= 1'b0;
        end
      endcase
    end
  end

  logic [IW-1:0] gnt_idx;

  // Registered ready gates the arbiter, so a lock drop only blocks grants from the next cycle.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .en      (ready),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    any_gnt   = |gnt;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  logic [2:0] rd_idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_chip_en <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_idx_q    <= '0;
    end else begin
      mem_chip_en <= any_gnt;
      mem_wr_en   <= any_gnt & sel_we;
      mem_rd_en   <= any_gnt & ~sel_we;
      if (any_gnt) begin
        mem_addr    <= sel_addr;
        mem_wr_data <= sel_wdata;
        rd_idx_q    <= 3'(gnt_idx);
      end
    end
  end

  // The mem_rd_en cycle acts as the head stage; the tag then trails the SRAM by RD_LATENCY edges.
  rd_tag_t tag_pipe [RD_LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= rd_tag_t'{vld: mem_rd_en, idx: rd_idx_q};
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = tag_pipe[RD_LATENCY-1].vld && (tag_pipe[RD_LATENCY-1].idx == 3'(i));
    end
  end

  assign rdata = mem_rd_data;

endmodule
